// File: rtl/fetch_decode_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue: instruction/PC widths,
// fetch exception status and the entry record stored per queue slot.
package fetch_decode_queue_pkg;

    localparam int INSTR_WIDTH       = 32;
    localparam int PC_WIDTH          = 32;
    localparam int FETCH_QUEUE_DEPTH = 4;

    // Carried alongside the instruction untouched; decode decides what to do with it.
    typedef struct packed {
        logic xcpt_bus_error;
        logic xcpt_page_fault;
        logic xcpt_misaligned;
    } fetch_xcpt_t;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]    pc;
        fetch_xcpt_t            xcpt;
    } fetch_queue_entry_t;

endpackage

// File: rtl/fetch_decode_queue.sv
// In-order instruction queue between fetch and decode: circular buffer with a
// separate occupancy counter, fetch back-pressure and a taken-branch flush.
module fetch_decode_queue
    import fetch_decode_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               fetch_instr_valid,
    input  logic [INSTR_WIDTH-1:0]             fetch_instr_data,
    input  logic [PC_WIDTH-1:0]                fetch_instr_pc,
    input  fetch_xcpt_t                        fetch_xcpt,
    output logic                               stall_fetch,
    input  logic                               stall_decode,
    output logic                               decode_instr_valid,
    output logic [INSTR_WIDTH-1:0]             decode_instr_data,
    output logic [PC_WIDTH-1:0]                decode_instr_pc,
    output fetch_xcpt_t                        decode_xcpt,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count,
    output logic                               overflow_error
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    fetch_queue_entry_t mem_reg [QUEUE_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               overflow_reg;

    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    fetch_queue_entry_t wr_entry;
    fetch_queue_entry_t head_entry;

    always_comb begin
        empty              = (count_reg == '0);
        full               = (count_reg == CNT_W'(QUEUE_DEPTH));
        // A full queue still accepts when the head leaves in the same cycle.
        stall_fetch        = full & stall_decode;
        decode_instr_valid = !empty & !flush;
        pop                = decode_instr_valid & !stall_decode;
        push               = fetch_instr_valid & !stall_fetch & !flush;

        wr_entry.instr     = fetch_instr_data;
        wr_entry.pc        = fetch_instr_pc;
        wr_entry.xcpt      = fetch_xcpt;

        head_entry         = empty ? '0 : mem_reg[rd_ptr_reg];
        decode_instr_data  = head_entry.instr;
        decode_instr_pc    = head_entry.pc;
        decode_xcpt        = head_entry.xcpt;
        queue_count        = count_reg;
        overflow_error     = overflow_reg;
    end

    // Storage is plain enable flops with no reset; stale slots are never presented.
    for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_slot
        always_ff @(posedge clock) begin
            if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                mem_reg[gi] <= wr_entry;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    // Sticky until reset; a flush does not hide an earlier lost instruction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (fetch_instr_valid && stall_fetch) begin
            overflow_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue: directed stimulus queues the expected
// decode stream, a monitor checks every entry decode consumes.
module tb_fetch_decode_queue;
    import fetch_decode_queue_pkg::*;

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic                      flush = 1'b0;
    logic                      fetch_instr_valid = 1'b0;
    logic [INSTR_WIDTH-1:0]    fetch_instr_data = '0;
    logic [PC_WIDTH-1:0]       fetch_instr_pc = '0;
    fetch_xcpt_t               fetch_xcpt = '0;
    logic                      stall_fetch;
    logic                      stall_decode = 1'b0;
    logic                      decode_instr_valid;
    logic [INSTR_WIDTH-1:0]    decode_instr_data;
    logic [PC_WIDTH-1:0]       decode_instr_pc;
    fetch_xcpt_t               decode_xcpt;
    logic [2:0]                queue_count;
    logic                      overflow_error;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_data_q [$];
    logic [31:0] exp_pc_q   [$];
    logic [2:0]  exp_xcpt_q [$];

    fetch_decode_queue #(.QUEUE_DEPTH(4)) dut (
        .clock              (clock),
        .reset              (reset),
        .flush              (flush),
        .fetch_instr_valid  (fetch_instr_valid),
        .fetch_instr_data   (fetch_instr_data),
        .fetch_instr_pc     (fetch_instr_pc),
        .fetch_xcpt         (fetch_xcpt),
        .stall_fetch        (stall_fetch),
        .stall_decode       (stall_decode),
        .decode_instr_valid (decode_instr_valid),
        .decode_instr_data  (decode_instr_data),
        .decode_instr_pc    (decode_instr_pc),
        .decode_xcpt        (decode_xcpt),
        .queue_count        (queue_count),
        .overflow_error     (overflow_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic clear_expected();
        exp_data_q.delete();
        exp_pc_q.delete();
        exp_xcpt_q.delete();
    endtask

    task automatic drive_push(input logic [31:0] d, input logic [31:0] pc,
                              input logic [2:0] x, input bit accepted);
        fetch_instr_valid = 1'b1;
        fetch_instr_data  = d;
        fetch_instr_pc    = pc;
        fetch_xcpt        = fetch_xcpt_t'(x);
        if (accepted) begin
            exp_data_q.push_back(d);
            exp_pc_q.push_back(pc);
            exp_xcpt_q.push_back(x);
        end
    endtask

    task automatic idle();
        fetch_instr_valid = 1'b0;
        fetch_instr_data  = '0;
        fetch_instr_pc    = '0;
        fetch_xcpt        = '0;
    endtask

    // Monitor: whatever decode consumes must be the oldest expected entry.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && decode_instr_valid && !stall_decode) begin
                if (exp_pc_q.size() == 0) begin
                    check("unexpected_pop_pc", 64'(decode_instr_pc), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    $display("pop  pc=%08h data=%08h xcpt=%03b", decode_instr_pc,
                             decode_instr_data, decode_xcpt);
                    check("pop_pc",   64'(decode_instr_pc),   64'(exp_pc_q.pop_front()));
                    check("pop_data", 64'(decode_instr_data), 64'(exp_data_q.pop_front()));
                    check("pop_xcpt", 64'(decode_xcpt),       64'(exp_xcpt_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fetch_xcpt_t bus_x;

        // Reset then idle
        sample();
        check("rst_valid",    64'(decode_instr_valid), 64'd0);
        check("rst_stall",    64'(stall_fetch),        64'd0);
        check("rst_count",    64'(queue_count),        64'd0);
        check("rst_overflow", 64'(overflow_error),     64'd0);
        check("rst_data",     64'(decode_instr_data),  64'd0);
        check("rst_pc",       64'(decode_instr_pc),    64'd0);
        check("rst_xcpt",     64'(decode_xcpt),        64'd0);
        reset = 1'b0;
        cyc();

        // Four pushes with decode stalled
        stall_decode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_push(32'hA000_0000 + 32'(i), 32'h1000 + 32'(4 * i), 3'b000, 1'b1);
            $display("push pc=%08h", fetch_instr_pc);
            if (i == 2) begin
                sample();
                check("fill_head_pc", 64'(decode_instr_pc), 64'h1000);
            end
            cyc();
        end
        idle();
        sample();
        check("full_count",  64'(queue_count),        64'd4);
        check("full_stall",  64'(stall_fetch),        64'd1);
        check("full_valid",  64'(decode_instr_valid), 64'd1);
        check("full_headpc", 64'(decode_instr_pc),    64'h1000);
        cyc();

        // Full queue, push and pop together; new entry wraps to slot 0
        stall_decode = 1'b0;
        drive_push(32'hA000_0010, 32'h1010, 3'b000, 1'b1);
        $display("push pc=%08h (full, popping)", fetch_instr_pc);
        sample();
        check("fullpop_stall", 64'(stall_fetch), 64'd0);
        cyc();
        idle();
        for (int k = 0; k < 4; k++) begin
            sample();
            if (k == 0) check("fullpop_count", 64'(queue_count), 64'd4);
            check("drain_valid", 64'(decode_instr_valid), 64'd1);
            cyc();
        end
        sample();
        check("drained_count", 64'(queue_count),        64'd0);
        check("drained_valid", 64'(decode_instr_valid), 64'd0);
        cyc();

        // Flush with three queued plus a simultaneous push and pop attempt
        stall_decode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_push(32'hB000_0000 + 32'(i), 32'h1100 + 32'(4 * i), 3'b000, 1'b1);
            $display("push pc=%08h", fetch_instr_pc);
            cyc();
        end
        stall_decode = 1'b0;
        flush = 1'b1;
        clear_expected();
        drive_push(32'hB000_2000, 32'h2000, 3'b000, 1'b0);
        $display("push pc=%08h with flush", fetch_instr_pc);
        sample();
        check("flush_valid", 64'(decode_instr_valid), 64'd0);
        check("flush_count", 64'(queue_count),        64'd3);
        cyc();
        flush = 1'b0;
        idle();
        sample();
        check("postflush_count", 64'(queue_count),        64'd0);
        check("postflush_valid", 64'(decode_instr_valid), 64'd0);
        cyc();

        // Overflow: push into a full, stalled queue
        stall_decode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_push(32'hC000_0000 + 32'(i), 32'h1200 + 32'(4 * i), 3'b000, 1'b1);
            $display("push pc=%08h", fetch_instr_pc);
            cyc();
        end
        drive_push(32'hC000_0300, 32'h1300, 3'b000, 1'b0);
        $display("push pc=%08h (overflow)", fetch_instr_pc);
        sample();
        check("ovf_stall",  64'(stall_fetch),    64'd1);
        check("ovf_before", 64'(overflow_error), 64'd0);
        cyc();
        idle();
        sample();
        check("ovf_set",    64'(overflow_error),  64'd1);
        check("ovf_count",  64'(queue_count),     64'd4);
        check("ovf_headpc", 64'(decode_instr_pc), 64'h1200);
        cyc();
        flush = 1'b1;
        clear_expected();
        sample();
        check("ovf_flush_valid", 64'(decode_instr_valid), 64'd0);
        cyc();
        flush = 1'b0;
        sample();
        check("ovf_sticky",      64'(overflow_error), 64'd1);
        check("ovf_flush_count", 64'(queue_count),    64'd0);
        cyc();

        // Exception status passes through
        bus_x = '0;
        bus_x.xcpt_bus_error = 1'b1;
        drive_push(32'hD000_0000, 32'h3000, 3'(bus_x), 1'b1);
        $display("push pc=%08h bus_error", fetch_instr_pc);
        cyc();
        idle();
        sample();
        check("xcpt_valid", 64'(decode_instr_valid),         64'd1);
        check("xcpt_pc",    64'(decode_instr_pc),            64'h3000);
        check("xcpt_bus",   64'(decode_xcpt.xcpt_bus_error), 64'd1);
        cyc();
        stall_decode = 1'b0;
        sample();
        cyc();
        sample();
        check("xcpt_drained", 64'(queue_count), 64'd0);
        cyc();

        // Empty queue: push and pop attempted together, no bypass
        drive_push(32'hE000_0000, 32'h4000, 3'b000, 1'b1);
        $display("push pc=%08h into empty", fetch_instr_pc);
        sample();
        check("empty_valid", 64'(decode_instr_valid), 64'd0);
        cyc();
        idle();
        sample();
        check("empty_next_valid", 64'(decode_instr_valid), 64'd1);
        check("empty_next_pc",    64'(decode_instr_pc),    64'h4000);
        cyc();
        sample();
        check("empty_drained", 64'(queue_count), 64'd0);
        cyc();

        // Asynchronous reset mid-operation
        stall_decode = 1'b1;
        drive_push(32'hF000_0000, 32'h5000, 3'b010, 1'b1);
        cyc();
        drive_push(32'hF000_0001, 32'h5004, 3'b001, 1'b1);
        cyc();
        idle();
        sample();
        check("prereset_count", 64'(queue_count), 64'd2);
        #1 reset = 1'b1;
        #1;
        $display("async reset asserted mid-cycle");
        check("areset_count",    64'(queue_count),        64'd0);
        check("areset_valid",    64'(decode_instr_valid), 64'd0);
        check("areset_pc",       64'(decode_instr_pc),    64'd0);
        check("areset_data",     64'(decode_instr_data),  64'd0);
        check("areset_overflow", 64'(overflow_error),     64'd0);
        check("areset_stall",    64'(stall_fetch),        64'd0);
        clear_expected();
        sample();
        reset = 1'b0;
        stall_decode = 1'b0;
        cyc();
        sample();
        check("postreset_valid", 64'(decode_instr_valid), 64'd0);

        check("scoreboard_empty", 64'(exp_pc_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
